xnor_dot_seq: RTL and testbench
===============================

// Module: xnor_dot_seq
// PURPOSE
// - Sequencer for binary (XNOR-popcount) dot products in the BMAC datapath.
// - Accepts activation/weight words over valid/ready and XNORs them.
// - Time-shares LUTS byte lookup units across the word, one group of LUTS bytes per cycle.
// - Accumulates the signed per-byte results (2*popcount-8) across words until 'last'.
// - Emits one saturated dot-product sum per vector over a valid/ready output.
// PARAMETERS
// - WORD_W  64  input word width in bits; multiple of 8*LUTS
// - LUTS    2   byte lookups per cycle; BEATS = WORD_W/(8*LUTS), must be >=1
// - ACC_W   16  signed accumulator/output width, >=8
// PORTS
// - clk        in   1       single clock, rising edge
// - rst        in   1       asynchronous, active-high reset
// - clr        in   1       synchronous abort/clear
// - in_valid   in   1       input word valid
// - in_ready   out  1       block can accept a word
// - act        in   WORD_W  activation bits
// - wgt        in   WORD_W  weight bits
// - in_last    in   1       word is the final word of the current vector
// - out_valid  out  1       out_sum valid
// - out_ready  in   1       consumer accepts out_sum
// - out_sum    out  ACC_W   signed dot-product sum (two's complement)
// - busy       out  1       state != IDLE
// BEHAVIOUR
// - Clock and reset: one clock; reset is asynchronous and active-high.
// - Reset values: state=IDLE, acc=0, beat=0, out_valid=0, out_sum=0, busy=0.
// - Reset values: in_ready=1 on the first cycle after reset deassertion.
// - States: IDLE, RUN, OUT.
// - IDLE:
//   - in_ready=1.
//   - On in_valid&in_ready, register x=~(act^wgt) and last_q=in_last; beat=0; go to RUN.
// - RUN:
//   - in_ready=0.
//   - Each cycle, byte lanes beat*LUTS .. beat*LUTS+LUTS-1 of x (lane 0 = x[7:0]) drive the LUTS lookups.
//   - Each lookup yields a 5-bit signed value: 2*pop(byte)-8, range -8..+8. 8'hFF must give +8, with no wrap.
//   - acc <= sat(acc + sum of lanes); the result is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//   - On beat==BEATS-1: if last_q, go to OUT with out_sum=sat result and out_valid=1; else go to IDLE and keep acc.
//   - Otherwise beat++.
// - OUT:
//   - out_valid=1; out_sum is held stable while out_ready=0.
//   - On out_ready: out_valid=0, acc=0, go to IDLE.
//   - There is no same-cycle input accept in OUT.
// - Latency: accept at cycle t; the last beat is at t+BEATS; out_valid rises at t+BEATS+1.
// - Throughput: one word per BEATS+1 cycles.
// - clr has priority over every handshake. In any state it forces IDLE, acc=0, out_valid=0, beat=0, and the input is not accepted that cycle.
// - rst asserted mid-RUN or mid-OUT aborts the operation; the partial sum is discarded.
// - Saturation is sticky per add only; a later negative word can pull acc back in range.
// - out_sum changes only when entering OUT or on reset/clr (reset/clr set it to 0).
// STRUCTURE
// - Shared package bmac_pkg:
//   - BYTE_W=8, LUT_W=5
//   - state_t enum {IDLE,RUN,OUT}
//   - function sat_add(acc, delta) parameterised on ACC_W
// - Sub-module xnor_pop_lut: 8-bit in -> LUT_W signed out (2*pop-8), purely combinational. Instantiate it LUTS times via generate.
// - The lane mux, adder tree, accumulator and FSM all live in xnor_dot_seq. Lane values are sign-extended to ACC_W+1 before the adder.
// TESTING
// - Defaults for all tests: WORD_W=64, LUTS=2, BEATS=4.
// - Basic match: act=wgt=64'hFFFF_FFFF_FFFF_FFFF, in_last=1 -> out_sum=+64; out_valid rises 5 cycles after accept.
// - Full mismatch: act=0, wgt=all ones, in_last=1 -> out_sum=-64. Then act=64'h0F0F_0F0F_0F0F_0F0F, wgt=0 -> out_sum=0.
// - Multi-word vector: word1 act=wgt (in_last=0), then word2 act=~wgt (in_last=1) -> exactly one out_valid, with out_sum=0.
// - Saturation (ACC_W=8): two matching words, last on the second -> out_sum=+127 (8'h7F), not -128.
// - Saturation (ACC_W=8): two mismatching words -> out_sum=-128.
// - Backpressure: hold out_ready=0 for 10 cycles -> out_sum stable, in_ready=0, busy=1. Release -> in_ready=1 on the next cycle, acc=0.
// - Abort: clr pulse at RUN beat 2 -> out_valid never rises, state=IDLE. The next vector (all-match, last) gives +64.
// - Abort: async rst mid-RUN -> all outputs at their reset values.

Source files
------------

// File: rtl/bmac_pkg.sv
// Shared types and helpers for the BMAC binary dot-product datapath.
// Saturating add is width-generic so any accumulator width up to 63 bits can share it.
package bmac_pkg;

    localparam int BYTE_W = 8;
    localparam int LUT_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] acc,
        input logic signed [63:0] delta,
        input int                 acc_w
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum   = acc + delta;
        max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (acc_w - 1));
        if (sum > max_v) begin
            sat_add = max_v;
        end else if (sum < min_v) begin
            sat_add = min_v;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/xnor_pop_lut.sv
// Byte lookup: maps an XNORed byte to its signed contribution 2*popcount-8.
// 5-bit modular arithmetic keeps 8'hFF at +8 without needing a wider temporary.
module xnor_pop_lut
    import bmac_pkg::*;
(
    input  logic        [BYTE_W-1:0] byte_in,
    output logic signed [LUT_W-1:0]  val_out
);

    logic [3:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            pop = pop + {3'b000, byte_in[i]};
        end
        val_out = $signed({pop, 1'b0}) - 5'sd8;
    end

endmodule

// File: rtl/xnor_dot_seq.sv
// XNOR-popcount dot-product sequencer: accepts a word, walks it LUTS bytes per beat,
// accumulates with saturation and emits one sum per vector after the 'last' word.
module xnor_dot_seq
    import bmac_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int LUTS   = 2,
    parameter int ACC_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W-1:0]       act,
    input  logic [WORD_W-1:0]       wgt,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    busy
);

    localparam int GRP_W  = BYTE_W * LUTS;
    localparam int BEATS  = WORD_W / GRP_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                    state_q, state_d;
    logic [WORD_W-1:0]         x_q, x_d;
    logic                      last_q, last_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic                      out_valid_q, out_valid_d;
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;

    logic [GRP_W-1:0]          grp;
    logic signed [LUT_W-1:0]   lane_val [LUTS];
    logic signed [ACC_W:0]     lane_sum;
    logic signed [ACC_W-1:0]   acc_sat;

    always_comb begin
        grp = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                grp = x_q[b*GRP_W +: GRP_W];
            end
        end
    end

    for (genvar g = 0; g < LUTS; g++) begin : g_lut
        xnor_pop_lut u_lut (
            .byte_in (grp[g*BYTE_W +: BYTE_W]),
            .val_out (lane_val[g])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LUTS; i++) begin
            lane_sum = lane_sum + {{(ACC_W + 1 - LUT_W){lane_val[i][LUT_W-1]}}, lane_val[i]};
        end
        acc_sat = ACC_W'(sat_add(64'(acc_q), 64'(lane_sum), ACC_W));
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        last_d      = last_q;
        beat_d      = beat_q;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;

        // clr outranks every handshake, including an input offered this cycle
        if (clr) begin
            state_d     = IDLE;
            beat_d      = '0;
            acc_d       = '0;
            out_sum_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        x_d     = ~(act ^ wgt);
                        last_d  = in_last;
                        beat_d  = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    acc_d = acc_sat;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        if (last_q) begin
                            state_d     = OUT;
                            out_sum_d   = acc_sat;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            last_q      <= 1'b0;
            beat_q      <= '0;
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            last_q      <= last_d;
            beat_q      <= beat_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_xnor_dot_seq.sv
// Directed bench: a 16-bit and an 8-bit accumulator instance share all stimulus,
// so the same vectors exercise both the normal range and saturation.
module tb_xnor_dot_seq;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clr = 1'b0;
    logic               in_valid = 1'b0;
    logic [63:0]        act = '0;
    logic [63:0]        wgt = '0;
    logic               in_last = 1'b0;
    logic               out_ready = 1'b0;

    logic               in_ready_a, out_valid_a, busy_a;
    logic signed [15:0] out_sum_a;
    logic               in_ready_b, out_valid_b, busy_b;
    logic signed [7:0]  out_sum_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xnor_dot_seq #(.WORD_W(64), .LUTS(2), .ACC_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .act(act), .wgt(wgt), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .busy(busy_a)
    );

    xnor_dot_seq #(.WORD_W(64), .LUTS(2), .ACC_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .act(act), .wgt(wgt), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .busy(busy_b)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [63:0] a, input logic [63:0] w, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        while (!(in_ready_a && in_ready_b) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_in_ready", longint'(in_ready_a && in_ready_b), 1);
        act      = a;
        wgt      = w;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // cycle count includes the accept cycle
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid_a && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("out_valid_a_seen", longint'(out_valid_a), 1);
        check("out_valid_b_seen", longint'(out_valid_b), 1);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_dropped", longint'(out_valid_a || out_valid_b), 0);
    endtask

    task automatic vector1(input string tag, input logic [63:0] a, input logic [63:0] w,
                           input longint exp_a, input longint exp_b);
        int cyc;
        send_word(a, w, 1'b1);
        wait_out(cyc);
        check({tag, "_sum16"}, out_sum_a, exp_a);
        check({tag, "_sum8"}, out_sum_b, exp_b);
        consume();
    endtask

    initial begin
        int cyc;
        int seen;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready_a), 1);
        check("rst_out_valid", longint'(out_valid_a), 0);
        check("rst_busy", longint'(busy_a), 0);
        check("rst_out_sum", out_sum_a, 0);

        // basic match with latency
        send_word(ONES, ONES, 1'b1);
        wait_out(cyc);
        check("latency", cyc, 5);
        check("match_sum16", out_sum_a, 64);
        check("match_sum8", out_sum_b, 64);
        consume();

        vector1("mismatch", 64'h0, ONES, -64, -64);
        vector1("nibble", 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 0, 0);
        vector1("one_bit", 64'h1, 64'h0, 62, 62);

        // multi-word vector: only the last word produces output
        send_word(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("mw_no_early_out", longint'(out_valid_a), 0);
        check("mw_idle_between", longint'(busy_a), 0);
        vector1("multiword", ~64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 0, 0);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid_a) seen++;
        end
        check("mw_single_out", seen, 0);

        // saturation
        send_word(ONES, ONES, 1'b0);
        vector1("sat_pos", ONES, ONES, 128, 127);
        send_word(64'h0, ONES, 1'b0);
        vector1("sat_neg", 64'h0, ONES, -128, -128);
        send_word(ONES, ONES, 1'b0);
        send_word(ONES, ONES, 1'b0);
        vector1("sat_recover", 64'h0, ONES, 64, 63);

        // backpressure, with an input offered while OUT is held
        send_word(ONES, ONES, 1'b1);
        wait_out(cyc);
        @(negedge clk);
        act      = 64'h0;
        wgt      = ONES;
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_sum", out_sum_a, 64);
            check("bp_in_ready", longint'(in_ready_a), 0);
            check("bp_busy", longint'(busy_a), 1);
        end
        in_valid = 1'b0;
        consume();
        check("bp_rel_in_ready", longint'(in_ready_a), 1);
        check("bp_rel_busy", longint'(busy_a), 0);
        vector1("after_bp", 64'h1, 64'h0, 62, 62);

        // clr in IDLE blocks a simultaneous input
        @(negedge clk);
        clr      = 1'b1;
        act      = ONES;
        wgt      = ONES;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("clr_idle_busy", longint'(busy_a), 0);
        check("clr_idle_in_ready", longint'(in_ready_a), 1);
        check("clr_idle_sum", out_sum_a, 0);

        // clr on RUN beat 2
        send_word(ONES, ONES, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_run_busy", longint'(busy_a), 0);
        check("clr_run_in_ready", longint'(in_ready_a), 1);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid_a || out_valid_b) seen++;
        end
        check("clr_no_out", seen, 0);
        vector1("after_clr", ONES, ONES, 64, 64);

        // async reset mid-RUN
        send_word(ONES, ONES, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_in_ready", longint'(in_ready_a), 1);
        check("arst_out_valid", longint'(out_valid_a), 0);
        check("arst_busy", longint'(busy_a), 0);
        check("arst_sum", out_sum_a, 0);
        @(negedge clk);
        rst = 1'b0;
        vector1("after_arst", 64'h0, ONES, -64, -64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
